// File: rtl/touch_pkg.sv
// Shared definitions for the touchscreen conditioning path: ADC width, FSM state type,
// and a helper that returns the absolute difference of two ADC codes.
package touch_pkg;

   localparam int unsigned TS_ADC_WIDTH = 12;
   localparam int unsigned TS_MAX_CODE  = 4095;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2
   } touch_state_t;

   // Unsigned |a - b| of two ADC codes.
   function automatic logic [TS_ADC_WIDTH-1:0] abs_diff(
      input logic [TS_ADC_WIDTH-1:0] a,
      input logic [TS_ADC_WIDTH-1:0] b
   );
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/touch_axis_accum.sv
// One axis of the touch filter: window accumulator, reference sample, jump detector and
// the averaged value that the window would produce if the current sample were added.
module touch_axis_accum
   import touch_pkg::*;
#(
   parameter int unsigned AVG_LOG2  = 2,
   parameter int unsigned MAX_DELTA = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic                    add,
   input  logic [TS_ADC_WIDTH-1:0] raw,
   output logic                    out_of_range,
   output logic [TS_ADC_WIDTH-1:0] avg
);

   localparam int unsigned ACC_W = TS_ADC_WIDTH + AVG_LOG2;

   logic [ACC_W-1:0]        acc;
   logic [ACC_W-1:0]        sum_next;
   logic [TS_ADC_WIDTH-1:0] ref_q;

   // Accumulator is sized so that a full window of max codes never overflows.
   assign sum_next     = acc + ACC_W'(raw);
   assign avg          = TS_ADC_WIDTH'(sum_next >> AVG_LOG2);
   assign out_of_range = abs_diff(raw, ref_q) > TS_ADC_WIDTH'(MAX_DELTA);

   always_ff @(posedge clk) begin
      if (reset) begin
         acc   <= '0;
         ref_q <= '0;
      end else if (load) begin
         acc   <= ACC_W'(raw);
         ref_q <= raw;
      end else if (add) begin
         acc   <= sum_next;
      end
   end

endmodule

// File: rtl/touch_filter.sv
// Averages pen-down touch samples in windows of 2**AVG_LOG2, rejects jumps, and hands one
// position at a time to the painter. Define TOUCH_FILTER_DEDUP_EN to suppress repeats.
module touch_filter
   import touch_pkg::*;
#(
   parameter int unsigned AVG_LOG2  = 2,
   parameter int unsigned MAX_DELTA = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    pen_down,
   input  logic                    sample_valid,
   input  logic [TS_ADC_WIDTH-1:0] x_raw,
   input  logic [TS_ADC_WIDTH-1:0] y_raw,
   input  logic                    painter_ready,
   output logic                    pos_ready,
   output logic [TS_ADC_WIDTH-1:0] x_pos,
   output logic [TS_ADC_WIDTH-1:0] y_pos,
   output logic                    sample_dropped
);

   localparam int unsigned CNT_W = AVG_LOG2 + 1;
   localparam int unsigned WIN   = 1 << AVG_LOG2;

   touch_state_t            state, state_next;
   logic [CNT_W-1:0]        count, count_next;
   logic                    win_load, win_add, capture;
   logic                    x_oor, y_oor;
   logic [TS_ADC_WIDTH-1:0] x_avg, y_avg;
   logic                    dup_c;

   touch_axis_accum #(.AVG_LOG2(AVG_LOG2), .MAX_DELTA(MAX_DELTA)) u_x (
      .clk(clk), .reset(reset), .load(win_load), .add(win_add),
      .raw(x_raw), .out_of_range(x_oor), .avg(x_avg)
   );

   touch_axis_accum #(.AVG_LOG2(AVG_LOG2), .MAX_DELTA(MAX_DELTA)) u_y (
      .clk(clk), .reset(reset), .load(win_load), .add(win_add),
      .raw(y_raw), .out_of_range(y_oor), .avg(y_avg)
   );

`ifdef TOUCH_FILTER_DEDUP_EN
   logic [TS_ADC_WIDTH-1:0] last_x, last_y;
   logic                    last_valid;

   assign dup_c = last_valid && (x_avg == last_x) && (y_avg == last_y);

   // Remembers the last position handed over; a lifted pen forgets it.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_x     <= '0;
         last_y     <= '0;
         last_valid <= 1'b0;
      end else if (en) begin
         if (!pen_down) begin
            last_valid <= 1'b0;
         end else if (pos_ready) begin
            last_x     <= x_pos;
            last_y     <= y_pos;
            last_valid <= 1'b1;
         end
      end
   end
`else
   assign dup_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // Next state, window control and the two combinational strobes.
   always_comb begin
      state_next     = state;
      count_next     = count;
      win_load       = 1'b0;
      win_add        = 1'b0;
      capture        = 1'b0;
      pos_ready      = 1'b0;
      sample_dropped = 1'b0;
      if (en) begin
         case (state)
            IDLE: begin
               if (sample_valid && pen_down) begin
                  win_load   = 1'b1;
                  count_next = CNT_W'(1);
                  state_next = ACCUM;
               end
            end
            ACCUM: begin
               if (!pen_down) begin
                  count_next = '0;
                  state_next = IDLE;
               end else if (sample_valid) begin
                  if (x_oor || y_oor) begin
                     win_load   = 1'b1;
                     count_next = CNT_W'(1);
                  end else begin
                     win_add = 1'b1;
                     if (count == CNT_W'(WIN - 1)) begin
                        capture    = 1'b1;
                        count_next = '0;
                        state_next = dup_c ? IDLE : EMIT;
                     end else begin
                        count_next = count + CNT_W'(1);
                     end
                  end
               end
            end
            EMIT: begin
               sample_dropped = sample_valid;
               if (painter_ready) begin
                  pos_ready  = 1'b1;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_pos <= '0;
         y_pos <= '0;
      end else if (capture) begin
         x_pos <= x_avg;
         y_pos <= y_avg;
      end
   end

endmodule

// File: tb/tb_touch_filter.sv
// Self-checking bench for touch_filter: directed scenarios plus a randomized run against
// a window-queue reference model. Honours TOUCH_FILTER_DEDUP_EN like the design.
module tb_touch_filter;

   localparam int N  = 4;
   localparam int MD = 64;

   logic        clk = 1'b0;
   logic        reset, en, pen_down, sample_valid, painter_ready;
   logic [11:0] x_raw, y_raw;
   logic        pos_ready, sample_dropped;
   logic [11:0] x_pos, y_pos;

   int errors = 0;
   int checks = 0;

   bit obs_pr, obs_drop, exp_pr, exp_drop;
   int n_str, n_drop;

   // Reference model: the open window as a list of samples, a pending-emission flag,
   // the registered position and the last position delivered.
   int m_wx[$];
   int m_wy[$];
   bit m_pend;
   int m_x, m_y, m_lx, m_ly;
   bit m_lvalid;

   touch_filter #(.AVG_LOG2(2), .MAX_DELTA(64)) dut (
      .clk(clk), .reset(reset), .en(en), .pen_down(pen_down),
      .sample_valid(sample_valid), .x_raw(x_raw), .y_raw(y_raw),
      .painter_ready(painter_ready), .pos_ready(pos_ready),
      .x_pos(x_pos), .y_pos(y_pos), .sample_dropped(sample_dropped)
   );

   always #5 clk = ~clk;

   // One clock cycle: apply inputs, sample the strobes, advance the model.
   task automatic drive(input bit r, input bit e, input bit p, input bit v,
                        input int x, input int y, input bit pr);
      int sx, sy;
      bit dup;
      @(negedge clk);
      reset = r; en = e; pen_down = p; sample_valid = v;
      x_raw = 12'(x); y_raw = 12'(y); painter_ready = pr;
      #1;
      obs_pr   = pos_ready;
      obs_drop = sample_dropped;
      exp_pr   = m_pend && e && pr;
      exp_drop = m_pend && e && v;
      n_str  += int'(obs_pr);
      n_drop += int'(obs_drop);
      if (r) begin
         m_wx.delete(); m_wy.delete();
         m_pend = 0; m_x = 0; m_y = 0; m_lx = 0; m_ly = 0; m_lvalid = 0;
      end else if (e) begin
         if (m_pend) begin
            if (pr) begin
               m_pend = 0; m_lx = m_x; m_ly = m_y; m_lvalid = 1;
            end
         end else if (m_wx.size() == 0) begin
            if (v && p) begin m_wx.push_back(x); m_wy.push_back(y); end
         end else if (!p) begin
            m_wx.delete(); m_wy.delete();
         end else if (v) begin
            if (x - m_wx[0] > MD || m_wx[0] - x > MD || y - m_wy[0] > MD || m_wy[0] - y > MD) begin
               m_wx.delete(); m_wy.delete();
            end
            m_wx.push_back(x); m_wy.push_back(y);
            if (m_wx.size() == N) begin
               sx = 0; sy = 0;
               foreach (m_wx[i]) begin sx += m_wx[i]; sy += m_wy[i]; end
               m_x = sx / N; m_y = sy / N;
               m_wx.delete(); m_wy.delete();
`ifdef TOUCH_FILTER_DEDUP_EN
               dup = m_lvalid && m_x == m_lx && m_y == m_ly;
`else
               dup = 0;
`endif
               m_pend = !dup;
            end
         end
         if (!p) m_lvalid = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1, 1, 0, 0, 0, 0, 1);
      drive(1, 1, 0, 0, 0, 0, 1);
      drive(0, 1, 0, 0, 0, 0, 1);
      checks++; if (x_pos !== 12'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", x_pos); end
      checks++; if (y_pos !== 12'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", y_pos); end
      checks++; if (obs_pr !== 1'b0) begin errors++; $display("FAIL reset_pos_ready: got %0b want 0", obs_pr); end
      checks++; if (obs_drop !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %0b want 0", obs_drop); end
   endtask

   task automatic test_average();
      n_str = 0;
      for (int i = 0; i < 4; i++) drive(0, 1, 1, 1, 1000 + 4 * i, 2000 + 4 * i, 1);
      checks++; if (n_str !== 0) begin errors++; $display("FAIL avg_early_strobe: got %0d want 0", n_str); end
      drive(0, 1, 1, 0, 0, 0, 1);
      checks++; if (obs_pr !== 1'b1) begin errors++; $display("FAIL avg_strobe: got %0b want 1", obs_pr); end
      checks++; if (x_pos !== 12'd1006) begin errors++; $display("FAIL avg_x: got %0d want 1006", x_pos); end
      checks++; if (y_pos !== 12'd2006) begin errors++; $display("FAIL avg_y: got %0d want 2006", y_pos); end
      drive(0, 1, 1, 0, 0, 0, 1);
      checks++; if (obs_pr !== 1'b0) begin errors++; $display("FAIL avg_strobe_width: got %0b want 0", obs_pr); end
   endtask

   task automatic test_restart();
      n_str = 0;
      drive(0, 1, 1, 1, 1000, 2000, 1);
      for (int i = 0; i < 4; i++) drive(0, 1, 1, 1, 1200, 2000, 1);
      checks++; if (n_str !== 0) begin errors++; $display("FAIL restart_early_strobe: got %0d want 0", n_str); end
      drive(0, 1, 1, 0, 0, 0, 1);
      checks++; if (obs_pr !== 1'b1) begin errors++; $display("FAIL restart_strobe: got %0b want 1", obs_pr); end
      checks++; if (x_pos !== 12'd1200) begin errors++; $display("FAIL restart_x: got %0d want 1200", x_pos); end
      checks++; if (y_pos !== 12'd2000) begin errors++; $display("FAIL restart_y: got %0d want 2000", y_pos); end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 4; i++) drive(0, 1, 1, 1, 800, 900, 0);
      n_str = 0; n_drop = 0;
      for (int i = 0; i < 10; i++) drive(0, 1, 1, (i == 2 || i == 5), 40, 40, 0);
      checks++; if (n_drop !== 2) begin errors++; $display("FAIL bp_dropped: got %0d want 2", n_drop); end
      checks++; if (n_str !== 0) begin errors++; $display("FAIL bp_no_strobe: got %0d want 0", n_str); end
      checks++; if (x_pos !== 12'd800 || y_pos !== 12'd900) begin
         errors++; $display("FAIL bp_hold: got %0d,%0d want 800,900", x_pos, y_pos);
      end
      drive(0, 1, 1, 0, 0, 0, 1);
      checks++; if (obs_pr !== 1'b1) begin errors++; $display("FAIL bp_strobe: got %0b want 1", obs_pr); end
      drive(0, 1, 1, 0, 0, 0, 1);
      checks++; if (obs_pr !== 1'b0) begin errors++; $display("FAIL bp_strobe_width: got %0b want 0", obs_pr); end
   endtask

   task automatic test_pen_lift();
      n_str = 0;
      for (int i = 0; i < 3; i++) drive(0, 1, 1, 1, 100, 100, 1);
      drive(0, 1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0, 0, 1);
      checks++; if (n_str !== 0) begin errors++; $display("FAIL lift_no_strobe: got %0d want 0", n_str); end
      checks++; if (x_pos !== 12'd800) begin errors++; $display("FAIL lift_x_hold: got %0d want 800", x_pos); end
      for (int i = 0; i < 4; i++) drive(0, 1, 1, 1, 500, 500, 1);
      drive(0, 1, 1, 0, 0, 0, 1);
      checks++; if (obs_pr !== 1'b1) begin errors++; $display("FAIL lift_strobe: got %0b want 1", obs_pr); end
      checks++; if (x_pos !== 12'd500 || y_pos !== 12'd500) begin
         errors++; $display("FAIL lift_pos: got %0d,%0d want 500,500", x_pos, y_pos);
      end
   endtask

   task automatic test_dedup_windows();
      int want2, want3;
`ifdef TOUCH_FILTER_DEDUP_EN
      want2 = 1; want3 = 2;
`else
      want2 = 2; want3 = 3;
`endif
      n_str = 0;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 4; i++) drive(0, 1, 1, 1, 300, 300, 1);
         drive(0, 1, 1, 0, 0, 0, 1);
      end
      checks++; if (n_str !== want2) begin errors++; $display("FAIL dedup_two: got %0d want %0d", n_str, want2); end
      drive(0, 1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) drive(0, 1, 1, 1, 300, 300, 1);
      drive(0, 1, 1, 0, 0, 0, 1);
      checks++; if (n_str !== want3) begin errors++; $display("FAIL dedup_three: got %0d want %0d", n_str, want3); end
   endtask

   task automatic test_reset_in_emit();
      for (int i = 0; i < 4; i++) drive(0, 1, 1, 1, 600, 600, 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      checks++; if (x_pos !== 12'd600) begin errors++; $display("FAIL rst_emit_pre_x: got %0d want 600", x_pos); end
      drive(1, 1, 1, 0, 0, 0, 0);
      n_str = 0;
      drive(0, 1, 1, 0, 0, 0, 1);
      checks++; if (obs_pr !== 1'b0) begin errors++; $display("FAIL rst_emit_strobe: got %0b want 0", obs_pr); end
      checks++; if (x_pos !== 12'd0 || y_pos !== 12'd0) begin
         errors++; $display("FAIL rst_emit_pos: got %0d,%0d want 0,0", x_pos, y_pos);
      end
      for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0, 0, 1);
      checks++; if (n_str !== 0) begin errors++; $display("FAIL rst_emit_lost: got %0d want 0", n_str); end
   endtask

   task automatic test_random();
      int cx, cy, x, y;
      bit r, e, p, v, pr;
      cx = 2000; cy = 2000;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 24) == 0) begin cx = $urandom_range(0, 4095); cy = $urandom_range(0, 4095); end
         if ($urandom_range(0, 2) == 0) begin
            x = cx; y = cy;
         end else begin
            x = cx + int'($urandom_range(0, 80)) - 40;
            y = cy + int'($urandom_range(0, 80)) - 40;
         end
         if (x < 0) x = 0; if (x > 4095) x = 4095;
         if (y < 0) y = 0; if (y > 4095) y = 4095;
         r  = ($urandom_range(0, 199) == 0);
         e  = ($urandom_range(0, 9) != 0);
         p  = ($urandom_range(0, 29) != 0);
         v  = ($urandom_range(0, 9) < 5);
         pr = ($urandom_range(0, 9) < 7);
         drive(r, e, p, v, x, y, pr);
         checks++; if (obs_pr !== exp_pr) begin
            errors++; $display("FAIL rnd_pos_ready c=%0d: got %0b want %0b", c, obs_pr, exp_pr);
         end
         checks++; if (obs_drop !== exp_drop) begin
            errors++; $display("FAIL rnd_dropped c=%0d: got %0b want %0b", c, obs_drop, exp_drop);
         end
         checks++; if (x_pos !== 12'(m_x) || y_pos !== 12'(m_y)) begin
            errors++; $display("FAIL rnd_pos c=%0d: got %0d,%0d want %0d,%0d", c, x_pos, y_pos, m_x, m_y);
         end
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; pen_down = 1'b0; sample_valid = 1'b0;
      x_raw = '0; y_raw = '0; painter_ready = 1'b1;
      m_pend = 0; m_x = 0; m_y = 0; m_lx = 0; m_ly = 0; m_lvalid = 0;
      n_str = 0; n_drop = 0;
      test_reset();
      test_average();
      test_restart();
      test_backpressure();
      test_pen_lift();
      test_dedup_windows();
      test_reset_in_emit();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/touch_filter.md
# touch_filter

Conditions raw LT24 touchscreen ADC samples before they reach the painter stage. It averages 2**AVG_LOG2 consecutive samples while the pen is down, rejects jumps larger than MAX_DELTA, and emits one filtered (x_pos, y_pos) with a pos_ready strobe when the painter reports ready. It sits between the touchscreen ADC driver and the painter; its outputs connect directly to the painter's pos_ready/x_pos/y_pos/painter_ready interface.

## Interface
- AVG_LOG2, 2: log2 of samples averaged per emitted position (1..4).
- MAX_DELTA, 64: maximum allowed per-axis |sample − window reference|, in ADC LSBs.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- en  in  1  global enable; low freezes all state.
- pen_down  in  1  pen-contact level from the touch driver, already synchronised.
- sample_valid  in  1  one-cycle strobe; x_raw/y_raw valid.
- x_raw  in  12  raw X ADC code.
- y_raw  in  12  raw Y ADC code.
- painter_ready  in  1  painter idle, able to accept a position.
- pos_ready  out  1  one-cycle strobe; x_pos/y_pos valid.
- x_pos  out  12  filtered X.
- y_pos  out  12  filtered Y.
- sample_dropped  out  1  one-cycle strobe: sample discarded while in EMIT.

## Operation
- Reset values: state IDLE, x_pos=0, y_pos=0, pos_ready=0, sample_dropped=0, accumulators=0, count=0, last_valid=0.
- States: IDLE, ACCUM, EMIT.
- IDLE: on sample_valid && pen_down, load acc_x=x_raw, acc_y=y_raw, ref_x=x_raw, ref_y=y_raw, count=1, and go to ACCUM. Samples with pen_down=0 are ignored.
- ACCUM: pen_down=0 discards the window and goes to IDLE. pen_down has priority over a same-cycle sample.
- ACCUM, on sample_valid:
  - If |x_raw−ref_x|>MAX_DELTA or |y_raw−ref_y|>MAX_DELTA, restart the window with this sample as the new reference (count=1).
  - Otherwise add the sample to the accumulators and increment count.
- When the add makes count = 2**AVG_LOG2, register x_pos=acc_x>>AVG_LOG2 and y_pos=acc_y>>AVG_LOG2 (truncating), then go to EMIT.
- Arithmetic:
  - Accumulators are 12+AVG_LOG2 bits unsigned and never overflow.
  - abs diff is computed as unsigned 12-bit, compared with >, not ≥.
- EMIT: pos_ready = (state==EMIT) && painter_ready && en, combinational from registered state.
  - The cycle pos_ready is high, go to IDLE and set last_x/last_y to x_pos/y_pos and last_valid=1.
  - While in EMIT, any sample_valid raises sample_dropped for that cycle and the sample is not used.
  - pen_down falling in EMIT does not cancel the pending emission.
- last_valid clears on reset and on any cycle with pen_down=0.
- en=0: no state or register updates, pos_ready=0, sample_dropped=0. Inputs arriving then are lost.

## Timing
- Final accepted sample at cycle t: x_pos/y_pos are valid and the state is EMIT from t+1.
- pos_ready is high in cycle t+1 if painter_ready is high, otherwise in the first later cycle with painter_ready=1.
- pos_ready is exactly one cycle wide. x_pos/y_pos stay stable from entry to EMIT until the next window completes.
- Minimum spacing between strobes: 2**AVG_LOG2 samples, plus 1 cycle.
- Reset mid-window or mid-EMIT: the next cycle is IDLE with outputs at reset values. A pending emission is lost.

## Configuration
- TOUCH_FILTER_DEDUP_EN defined: on entering EMIT, if last_valid and the new x_pos/y_pos equal last_x/last_y, skip EMIT and go to IDLE. No pos_ready is raised, and the painter is not re-fed a stationary pen.
- Undefined: every completed window emits. last_x/last_y/last_valid are not implemented.

## Structure
- Shared package touch_pkg holds:
  - TS_ADC_WIDTH=12;
  - the state typedef (IDLE, ACCUM, EMIT);
  - TS_MAX_CODE=4095.
- Sub-module touch_axis_accum (parameters AVG_LOG2, MAX_DELTA) is instantiated once per axis. It holds the accumulator and reference, computes the out-of-range flag, and provides the averaged value.
- Control FSM, count, dedup and strobes live in the top.

## Test plan
Defaults used: AVG_LOG2=2, MAX_DELTA=64, painter_ready=1 unless stated.
- Four samples (1000,2000),(1004,2004),(1008,2008),(1012,2012) with pen_down=1 → pos_ready one cycle after the 4th, x_pos=1006, y_pos=2006.
- Samples (1000,2000),(1200,2000),(1200,2000),(1200,2000),(1200,2000) → 2nd restarts the window; single emission x_pos=1200, y_pos=2000 after the 5th.
- Window completes with painter_ready=0 for 10 cycles, sample_valid pulsed twice meanwhile → sample_dropped twice, pos_ready only in the first cycle painter_ready=1, x_pos unchanged.
- pen_down drops after 3 samples → no pos_ready. Then 4 fresh samples of (500,500) → x_pos=500, y_pos=500.
- With TOUCH_FILTER_DEDUP_EN, two consecutive windows of (300,300) → one pos_ready. After a pen_down low cycle, a third window → a second pos_ready. Without the macro → two then three strobes.
- Reset asserted in EMIT with painter_ready=0 → next cycle pos_ready=0, x_pos=0, y_pos=0, state IDLE.
